// File: rtl/fpm_pkg.sv
// fpm_pkg: single-precision field widths and word type shared by the multiplier arbiter.
package fpm_pkg;
  localparam int P_W = 32;
  localparam int E_W = 8;
  localparam int M_W = 23;
  localparam logic [E_W-1:0] BIAS = 8'd127;
  typedef logic [P_W-1:0] fp32_t;
endpackage

// File: rtl/fpm_share_arb_if.sv
// fpm_share_arb_if: requester operand ports and product response port of the shared multiplier.
interface fpm_share_arb_if
  import fpm_pkg::*;
#(
  parameter int N   = 4,
  parameter int P   = P_W,
  parameter int IDW = $clog2(N)
);
  logic [N-1:0]   req_valid;
  logic [N*P-1:0] req_a;
  logic [N*P-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [P-1:0]   rsp_prod;
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_prod
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_prod
  );
endinterface

// File: rtl/rr_arb.sv
// rr_arb: round-robin arbiter; scans from r_ptr and moves the pointer past each issued grant.
module rr_arb
  import fpm_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           advance,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any_grant
);
  logic [IDW-1:0] r_ptr;
  logic [IDW:0]   w_pos;
  // Scan highest offset first so the nearest requester at or after r_ptr wins last.
  always_comb begin
    grant_idx = '0;
    any_grant = 1'b0;
    w_pos     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_pos = {1'b0, r_ptr} + (IDW+1)'(k);
      w_pos = (w_pos >= (IDW+1)'(N)) ? w_pos - (IDW+1)'(N) : w_pos;
      if (req[w_pos[IDW-1:0]]) begin
        grant_idx = w_pos[IDW-1:0];
        any_grant = 1'b1;
      end
    end
  end
  assign grant = any_grant ? (N'(1) << grant_idx) : '0;
  always_ff @(posedge clk) begin
    if (rst) r_ptr <= '0;
    else if (advance && any_grant) r_ptr <= (grant_idx == IDW'(N - 1)) ? '0 : grant_idx + IDW'(1);
  end
endmodule

// File: rtl/fpm_share_arb.sv
// fpm_share_arb: round-robin sharing of one combinational fp32 multiplier through a two-stage
// operand/product pipeline; products return in issue order tagged with the requester index.
module fpm_share_arb
  import fpm_pkg::*;
#(
  parameter int N   = 4,
  parameter int P   = P_W,
  parameter int IDW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  fpm_share_arb_if.slave  bus,
  output logic [P-1:0]    mul_a,
  output logic [P-1:0]    mul_b,
  input  logic [P-1:0]    mul_p,
  output logic            busy
);
  logic           r_s1_v, r_s2_v;
  logic [IDW-1:0] r_s1_id, r_rsp_id;
  logic [P-1:0]   r_mul_a, r_mul_b, r_prod;
  logic           w_adv1, w_adv2, w_any;
  logic [N-1:0]   w_grant;
  logic [IDW-1:0] w_g;
  assign w_adv2 = ~r_s2_v | bus.rsp_ready;
  assign w_adv1 = ~r_s1_v | w_adv2;
  rr_arb #(.N(N), .IDW(IDW)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (bus.req_valid),
    .advance   (w_adv1),
    .grant     (w_grant),
    .grant_idx (w_g),
    .any_grant (w_any)
  );
  assign bus.req_ready = w_grant & {N{w_adv1 & w_any}};
  // Operand registers only load on a grant so the multiplier never sees stale-bus garbage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      r_mul_a  <= '0;
      r_mul_b  <= '0;
      r_s1_id  <= '0;
      r_prod   <= '0;
      r_rsp_id <= '0;
    end else begin
      if (w_adv2) begin
        r_s2_v <= r_s1_v;
        if (r_s1_v) begin
          r_prod   <= mul_p;
          r_rsp_id <= r_s1_id;
        end
      end
      if (w_adv1) begin
        r_s1_v <= w_any;
        if (w_any) begin
          r_mul_a <= bus.req_a[w_g*P +: P];
          r_mul_b <= bus.req_b[w_g*P +: P];
          r_s1_id <= w_g;
        end
      end
    end
  end
  assign mul_a         = r_mul_a;
  assign mul_b         = r_mul_b;
  assign bus.rsp_valid = r_s2_v;
  assign bus.rsp_prod  = r_prod;
  assign bus.rsp_id    = r_rsp_id;
  assign busy          = r_s1_v | r_s2_v;
endmodule

// File: tb/tb_fpm_share_arb.sv
// tb_fpm_share_arb: directed vectors; issues push expected responses, a monitor pops and compares.
module tb_fpm_share_arb;
  localparam int N = 4;
  localparam int P = 32;
  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] prod;
  } rsp_t;
  logic        clk, rst;
  logic [31:0] mul_a, mul_b, mul_p;
  logic        busy;
  int          n_checks = 0;
  int          n_fail = 0;
  rsp_t        q[$];
  rsp_t        e;
  logic [31:0] t2_prod [4] = '{32'h40000000, 32'h40800000, 32'h40C00000, 32'h41000000};
  fpm_share_arb_if #(.N(N), .P(P)) bus ();
  fpm_share_arb #(.N(N), .P(P)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus),
    .mul_a (mul_a),
    .mul_b (mul_b),
    .mul_p (mul_p),
    .busy  (busy)
  );
  // Bench-side multiplier: normal operands only, zero/denormal inputs flush to +0, truncating.
  function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
    logic [47:0] m;
    logic [9:0]  ex;
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return 32'h0;
    m  = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    ex = {2'b0, a[30:23]} + {2'b0, b[30:23]} - 10'd127 + {9'b0, m[47]};
    return {a[31] ^ b[31], ex[7:0], m[47] ? m[46:24] : m[45:23]};
  endfunction
  assign mul_p = fmul(mul_a, mul_b);
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, need 0x%0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic idle(input int n);
    repeat (n) tick();
  endtask
  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[i*P +: P] = a;
    bus.req_b[i*P +: P] = b;
  endtask
  task automatic expect_issue(input string nm, input logic [3:0] rdy, input logic [1:0] id,
                              input logic [31:0] prod);
    @(negedge clk);
    chk(nm, 64'(bus.req_ready), 64'(rdy));
    if (rdy != 4'b0) q.push_back({id, prod});
    tick();
  endtask
  always @(negedge clk) begin
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      if (q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL rsp_extra: got id %0d prod 0x%0h, need no response", bus.rsp_id, bus.rsp_prod);
      end else begin
        e = q.pop_front();
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
        chk("rsp_prod", 64'(bus.rsp_prod), 64'(e.prod));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout: got no end of test, need $finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.rsp_ready = 1'b1;
    idle(2);
    @(negedge clk);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    chk("rst_mul_a", 64'(mul_a), 64'd0);
    chk("rst_mul_b", 64'(mul_b), 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_rsp_prod", 64'(bus.rsp_prod), 64'd0);
    tick();
    rst = 1'b0;
    // single request, two-cycle latency
    set_op(1, 32'h40000000, 32'h40400000);
    bus.req_valid = 4'b0010;
    expect_issue("t1_ready", 4'b0010, 2'd1, 32'h40C00000);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("t1_lat1_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t1_lat1_busy", 64'(busy), 64'd1);
    tick();
    @(negedge clk);
    chk("t1_lat2_valid", 64'(bus.rsp_valid), 64'd1);
    tick();
    // all four requesters continuously valid after reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(0, 32'h3F800000, 32'h40000000);
    set_op(1, 32'h40000000, 32'h40000000);
    set_op(2, 32'h40400000, 32'h40000000);
    set_op(3, 32'h40800000, 32'h40000000);
    bus.req_valid = 4'b1111;
    for (int k = 0; k < 5; k++)
      expect_issue("t2_ready", 4'b0001 << (k % 4), 2'(k % 4), t2_prod[k % 4]);
    bus.req_valid = 4'b0000;
    idle(3);
    // backpressure with two back-to-back issues and a third waiting
    set_op(0, 32'h40000000, 32'h40000000);
    set_op(1, 32'h3F800000, 32'h40400000);
    bus.req_valid = 4'b0011;
    expect_issue("t3_issue1", 4'b0010, 2'd1, 32'h40400000);
    bus.req_valid = 4'b0001;
    expect_issue("t3_issue2", 4'b0001, 2'd0, 32'h40800000);
    bus.rsp_ready = 1'b0;
    set_op(0, 32'h40800000, 32'h40800000);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("t3_stall_ready", 64'(bus.req_ready), 64'd0);
      chk("t3_stall_valid", 64'(bus.rsp_valid), 64'd1);
      chk("t3_stall_id", 64'(bus.rsp_id), 64'd1);
      chk("t3_stall_prod", 64'(bus.rsp_prod), 64'h40400000);
      chk("t3_stall_mul_a", 64'(mul_a), 64'h40000000);
      tick();
    end
    bus.rsp_ready = 1'b1;
    expect_issue("t3_issue3", 4'b0001, 2'd0, 32'h41800000);
    bus.req_valid = 4'b0000;
    idle(3);
    // pointer wrap, fairness, zero and sign operands
    set_op(2, 32'h40400000, 32'h40400000);
    bus.req_valid = 4'b0100;
    expect_issue("t4_grant2", 4'b0100, 2'd2, 32'h41100000);
    set_op(3, 32'hC0000000, 32'h40400000);
    set_op(0, 32'h00000000, 32'hC1200000);
    bus.req_valid = 4'b1001;
    expect_issue("t4_grant3", 4'b1000, 2'd3, 32'hC0C00000);
    bus.req_valid = 4'b0001;
    expect_issue("t4_grant0", 4'b0001, 2'd0, 32'h00000000);
    set_op(0, 32'hBF800000, 32'h3F800000);
    expect_issue("t4_grant0_again", 4'b0001, 2'd0, 32'hBF800000);
    bus.req_valid = 4'b0000;
    idle(3);
    // reset with both stages full; those operations produce no response
    bus.rsp_ready = 1'b0;
    set_op(1, 32'h40A00000, 32'h40000000);
    set_op(2, 32'h3F800000, 32'h3F800000);
    bus.req_valid = 4'b0110;
    @(negedge clk);
    chk("t6_fill1", 64'(bus.req_ready), 64'b0010);
    tick();
    @(negedge clk);
    chk("t6_fill2", 64'(bus.req_ready), 64'b0100);
    tick();
    @(negedge clk);
    chk("t6_full_busy", 64'(busy), 64'd1);
    chk("t6_full_valid", 64'(bus.rsp_valid), 64'd1);
    tick();
    rst = 1'b1;
    bus.req_valid = 4'b0000;
    tick();
    @(negedge clk);
    chk("t6_rst_valid", 64'(bus.rsp_valid), 64'd0);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_ready", 64'(bus.req_ready), 64'd0);
    tick();
    rst = 1'b0;
    bus.rsp_ready = 1'b1;
    set_op(3, 32'h40000000, 32'h40000000);
    bus.req_valid = 4'b1010;
    expect_issue("t6_first_grant", 4'b0010, 2'd1, 32'h41200000);
    bus.req_valid = 4'b0000;
    idle(4);
    @(negedge clk);
    chk("end_queue_empty", 64'(q.size()), 64'd0);
    chk("end_busy", 64'(busy), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fpm_share_arb.md
Name: fpm_share_arb

Overview:
- Shares one combinational single-precision multiplier (IEEE-754 layout: 1 sign, 8 exponent, 23 mantissa bits) between N requesters.
- Each requester has a valid/ready operand port. Arbitration is round-robin.
- The block registers operands into the multiplier and captures the product into an output register. Each product is returned on a single response port, tagged with the requester index.
- Sits between the compute clients and the multiplier instance.

Parameters:
- N, 4, number of requesters (2..16).
- P, 32, operand/product width (multiplier word width).
- IDW, $clog2(N), requester tag width (2 for default).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  N  requester i has operands pending.
- req_a  input  N*P  operand A, requester i at bits [i*P +: P].
- req_b  input  N*P  operand B, same packing.
- req_ready  output  N  one-hot; requester i's operands accepted this cycle.
- mul_a  output  P  registered operand A to multiplier.
- mul_b  output  P  registered operand B to multiplier.
- mul_p  input  P  combinational product from multiplier (function of mul_a, mul_b).
- rsp_valid  output  1  rsp_prod/rsp_id hold a product.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of requester owning rsp_prod.
- rsp_prod  output  P  product.
- busy  output  1  s1_v | s2_v.

Behaviour:
- Reset: s1_v=0, s2_v=0, rr_ptr=0, mul_a=0, mul_b=0, s1_id=0, rsp_prod=0, rsp_id=0. Consequently rsp_valid=0, busy=0, req_ready=0.
- Reset applies mid-operation. In-flight operations are dropped with no response. Requesters must re-present their operands.
- Two-stage pipeline:
  - S1 consists of mul_a/mul_b/s1_id/s1_v.
  - S2 consists of rsp_prod/rsp_id/s2_v. rsp_valid = s2_v.
- Stage enables:
  - adv2 = ~s2_v | rsp_ready.
  - adv1 = ~s1_v | adv2.
- S2 update when adv2: s2_v<=s1_v. If s1_v: rsp_prod<=mul_p, rsp_id<=s1_id.
- S1 update when adv1: s1_v<=any_grant. If any_grant: mul_a<=req_a[g], mul_b<=req_b[g], s1_id<=g.
- Issue rules:
  - Issue is allowed only when adv1.
  - req_ready = onehot(g) & {N{adv1 & any_grant}}.
  - req_ready is combinational from req_valid, rsp_ready and state.
  - A requester must hold valid/operands stable until ready.
- Latency: operands accepted in cycle T appear with rsp_valid=1 in cycle T+2 (no backpressure). Throughput is one operation per cycle.
- Backpressure: while rsp_valid=1 and rsp_ready=0, rsp_prod/rsp_id are held stable. S1 holds if full, and no new grant is issued.
- Arbitration:
  - g = first index i with req_valid[i], scanning rr_ptr, rr_ptr+1, ... mod N.
  - On issue, rr_ptr <= (g+1) mod N, wrapping N-1 -> 0.
  - rr_ptr is unchanged when nothing issues.
- Products are not altered; zero/sign/exponent handling is the multiplier's.
- Responses return strictly in issue order.
- No X propagation: mul_a/mul_b are unchanged on cycles with adv1=1 and no grant.

Decomposition:
- Shared package fpm_pkg: P_W=32, E_W=8, M_W=23, BIAS=8'd127, typedef logic [31:0] fp32_t.
- One sub-module, rr_arb: N-bit round-robin arbiter.
  - Inputs: clk, rst, req, advance.
  - Outputs: grant onehot, grant_idx, any_grant.
  - Owns rr_ptr.
- The multiplier remains a separate instance outside this block; the bench instantiates it.

Test Plan:
1. Single request: req_valid=4'b0010, A=0x40000000 (2.0), B=0x40400000 (3.0), rsp_ready=1.
   -> req_ready=4'b0010 at T; at T+2 rsp_valid=1, rsp_id=1, rsp_prod=0x40C00000 (6.0).
2. All four valid continuously, rsp_ready=1, after reset.
   -> grants 0,1,2,3,0,... one per cycle; rsp_id sequence 0,1,2,3 starting T+2.
3. Backpressure: two back-to-back issues, rsp_ready=0 for 3 cycles.
   -> rsp_prod/rsp_id stable; S1 holds the second op; req_ready=0 for all requesters.
   -> After rsp_ready=1, both responses delivered in order, nothing lost or duplicated.
4. Wrap and fairness: rr_ptr=3 after granting 2; req_valid=4'b1001.
   -> grant 3, then 0. Next, with only 4'b0001 valid, grant 0 again.
5. Zero operand: A=0x00000000, B=0xC1200000.
   -> rsp_prod=0x00000000.
   -> Sign product: A=0xBF800000, B=0x3F800000 -> 0xBF800000.
6. Reset mid-flight: assert rst with s1_v=s2_v=1.
   -> next cycle rsp_valid=0, busy=0, rr_ptr=0; first grant after release goes to the lowest valid index.
